// File: rtl/i2c_sensor_poller.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sensor_poller
// Description : Periodic register-read sequencer in front of an I2C master.
//               On each poll tick it reads NUM_BYTES consecutive registers
//               (pointer write + single-byte read per byte), assembles them
//               into a sample word (byte 0 in the MSBs) and emits a one-cycle
//               valid pulse. NAK, master error or a hung transaction abort
//               the sample with an error pulse, a saturating error count and
//               a master reset request.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sensor_poller #(
    parameter int          POLL_CYCLES    = 5_000_000,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h68,
    parameter logic [7:0]  REG_BASE       = 8'h3B,
    parameter int          NUM_BYTES      = 6,
    parameter int          TIMEOUT_CYCLES = 100_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   i2c_busy,
    input  logic                   i2c_done,
    input  logic                   i2c_error,
    input  logic [7:0]             i2c_data_out,
    output logic                   start_cmd,
    output logic [6:0]             slave_addr,
    output logic                   rw_bit,
    output logic [7:0]             data_in,
    output logic                   last_byte,
    output logic                   i2c_rst_req,
    output logic [8*NUM_BYTES-1:0] sample_data,
    output logic                   sample_valid,
    output logic                   sample_error,
    output logic [7:0]             err_count
);

    localparam logic [31:0] c_POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] c_TIMEOUT   = 32'(TIMEOUT_CYCLES);
    localparam logic [3:0]  c_LAST_IDX  = 4'(NUM_BYTES - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_WR_START = 4'd1;
    localparam logic [3:0] c_WR_ACK   = 4'd2;
    localparam logic [3:0] c_WR_WAIT  = 4'd3;
    localparam logic [3:0] c_RD_START = 4'd4;
    localparam logic [3:0] c_RD_ACK   = 4'd5;
    localparam logic [3:0] c_RD_WAIT  = 4'd6;
    localparam logic [3:0] c_DONE     = 4'd7;
    localparam logic [3:0] c_FAIL     = 4'd8;

    logic [3:0]             r_state;
    logic [3:0]             r_idx;
    logic [31:0]            r_poll_cnt;
    logic [31:0]            r_txn_timer;
    logic                   r_start_cmd;
    logic                   r_rw_bit;
    logic [7:0]             r_data_in;
    logic                   r_rst_req;
    logic [8*NUM_BYTES-1:0] r_shadow;
    logic [8*NUM_BYTES-1:0] r_sample_data;
    logic                   r_sample_valid;
    logic                   r_sample_error;
    logic [7:0]             r_err_count;

    logic                   w_tick;
    logic                   w_complete;
    logic [8*NUM_BYTES-1:0] w_shadow_upd;

    // A transaction is finished once busy has dropped and done is reported.
    assign w_complete = !i2c_busy && i2c_done;
    assign w_tick     = enable && (r_poll_cnt == c_POLL_LAST);

    // Shadow word with the freshly read byte merged in at position r_idx.
    always_comb begin
        w_shadow_upd = r_shadow;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (r_idx == 4'(i)) begin
                w_shadow_upd[(NUM_BYTES-1-i)*8 +: 8] = i2c_data_out;
            end
        end
    end

    // Free-running poll timer; held at zero while polling is disabled.
    always_ff @(posedge clk) begin
        if (rst || !enable || w_tick) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + 32'd1;
        end
    end

    // Sequencer: pointer write / byte read per register, then publish or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_idx          <= '0;
            r_txn_timer    <= '0;
            r_start_cmd    <= 1'b0;
            r_rw_bit       <= 1'b0;
            r_data_in      <= REG_BASE;
            r_rst_req      <= 1'b0;
            r_shadow       <= '0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_sample_error <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_start_cmd    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_error <= 1'b0;
            r_rst_req      <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // Ticks outside IDLE are simply never seen here.
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_state <= c_WR_START;
                    end
                end
                c_WR_START: begin
                    r_start_cmd <= 1'b1;
                    r_rw_bit    <= 1'b0;
                    r_data_in   <= REG_BASE + {4'b0000, r_idx};
                    r_txn_timer <= '0;
                    r_state     <= c_WR_ACK;
                end
                c_RD_START: begin
                    // data_in keeps the pointer; the master ignores it on reads.
                    r_start_cmd <= 1'b1;
                    r_rw_bit    <= 1'b1;
                    r_txn_timer <= '0;
                    r_state     <= c_RD_ACK;
                end
                c_WR_ACK, c_WR_WAIT, c_RD_ACK, c_RD_WAIT: begin
                    // Error is checked first so it wins over a same-cycle completion.
                    if (i2c_error || (r_txn_timer == c_TIMEOUT)) begin
                        r_state        <= c_FAIL;
                        r_sample_error <= 1'b1;
                        r_rst_req      <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end else begin
                        r_txn_timer <= r_txn_timer + 32'd1;
                        case (r_state)
                            // ACK states only look at busy, masking a stale done.
                            c_WR_ACK: if (i2c_busy) r_state <= c_WR_WAIT;
                            c_WR_WAIT: if (w_complete) r_state <= c_RD_START;
                            c_RD_ACK: if (i2c_busy) r_state <= c_RD_WAIT;
                            default: begin
                                if (w_complete) begin
                                    r_shadow <= w_shadow_upd;
                                    if (r_idx == c_LAST_IDX) begin
                                        r_sample_data  <= w_shadow_upd;
                                        r_sample_valid <= 1'b1;
                                        r_state        <= c_DONE;
                                    end else begin
                                        r_idx   <= r_idx + 4'd1;
                                        r_state <= c_WR_START;
                                    end
                                end
                            end
                        endcase
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                c_FAIL:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign start_cmd    = r_start_cmd;
    assign slave_addr   = SLAVE_ADDR;
    assign rw_bit       = r_rw_bit;
    assign data_in      = r_data_in;
    assign last_byte    = 1'b1;
    assign i2c_rst_req  = r_rst_req;
    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign sample_error = r_sample_error;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_i2c_sensor_poller.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_sensor_poller
// Description : Directed self-checking bench for i2c_sensor_poller with a
//               behavioural I2C master model (normal, NAK, hang, stale done,
//               slow) and a second fast-polling instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_sensor_poller;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic        i2c_busy, i2c_done, i2c_error;
    logic [7:0]  i2c_data_out;
    logic        start_cmd, rw_bit, last_byte, i2c_rst_req;
    logic [6:0]  slave_addr;
    logic [7:0]  data_in, err_count;
    logic [15:0] sample_data;
    logic        sample_valid, sample_error;

    // saturation instance
    logic        s_rst, s_enable, s_busy, s_error;
    logic        s_done = 1'b0;
    logic [7:0]  s_rdata = 8'h00;
    logic        s_start, s_rw, s_last, s_rstreq, s_valid, s_serr;
    logic [6:0]  s_addr;
    logic [7:0]  s_din, s_errcnt;
    logic [15:0] s_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0, errp_cnt = 0, rstreq_cnt = 0, last_err_cyc = 0;
    int s_n = 0;
    logic       st_rw[$];
    logic [7:0] st_data[$];
    int         st_cyc[$];

    logic [7:0] regmem [256];
    logic [7:0] last_ptr;
    logic       m_rw;
    logic [7:0] m_ptr;
    bit nak_once = 0, hang_once = 0, stale_mode = 0, slow_mode = 0;

    always #5 clk = ~clk;

    i2c_sensor_poller #(
        .POLL_CYCLES(1000), .SLAVE_ADDR(7'h68), .REG_BASE(8'h3B),
        .NUM_BYTES(2), .TIMEOUT_CYCLES(200)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_error(i2c_error),
        .i2c_data_out(i2c_data_out), .start_cmd(start_cmd),
        .slave_addr(slave_addr), .rw_bit(rw_bit), .data_in(data_in),
        .last_byte(last_byte), .i2c_rst_req(i2c_rst_req),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_error(sample_error), .err_count(err_count)
    );

    i2c_sensor_poller #(
        .POLL_CYCLES(16), .SLAVE_ADDR(7'h68), .REG_BASE(8'h3B),
        .NUM_BYTES(2), .TIMEOUT_CYCLES(200)
    ) u_sat (
        .clk(clk), .rst(s_rst), .enable(s_enable),
        .i2c_busy(s_busy), .i2c_done(s_done), .i2c_error(s_error),
        .i2c_data_out(s_rdata), .start_cmd(s_start),
        .slave_addr(s_addr), .rw_bit(s_rw), .data_in(s_din),
        .last_byte(s_last), .i2c_rst_req(s_rstreq),
        .sample_data(s_data), .sample_valid(s_valid),
        .sample_error(s_serr), .err_count(s_errcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_start"},  {31'd0, start_cmd},    32'd0);
        check({pfx, "_rw"},     {31'd0, rw_bit},       32'd0);
        check({pfx, "_din"},    {24'd0, data_in},      32'h3B);
        check({pfx, "_data"},   {16'd0, sample_data},  32'd0);
        check({pfx, "_valid"},  {31'd0, sample_valid}, 32'd0);
        check({pfx, "_serr"},   {31'd0, sample_error}, 32'd0);
        check({pfx, "_rstreq"}, {31'd0, i2c_rst_req},  32'd0);
        check({pfx, "_errcnt"}, {24'd0, err_count},    32'd0);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int v0 = valid_cnt;
        int n = 0;
        while (valid_cnt == v0 && n < budget) begin @(posedge clk); n++; end
        check({tag, "_valid_seen"}, 32'(valid_cnt - v0), 32'd1);
    endtask

    task automatic wait_err(input int budget, input string tag);
        int e0 = errp_cnt;
        int n = 0;
        while (errp_cnt == e0 && n < budget) begin @(posedge clk); n++; end
        check({tag, "_err_seen"}, 32'(errp_cnt - e0), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (st_rw.size() < target && n < budget) begin @(posedge clk); n++; end
        check({tag, "_starts_seen"}, {31'd0, st_rw.size() >= target}, 32'd1);
    endtask

    // observation of the main instance, away from the active edge
    initial forever begin
        @(negedge clk);
        cyc++;
        if (start_cmd) begin
            st_rw.push_back(rw_bit);
            st_data.push_back(data_in);
            st_cyc.push_back(cyc);
        end
        if (sample_valid) valid_cnt++;
        if (sample_error) begin errp_cnt++; last_err_cyc = cyc; end
        if (i2c_rst_req) rstreq_cnt++;
    end

    // behavioural master for the main instance
    initial begin
        i2c_busy = 0; i2c_done = 0; i2c_error = 0; i2c_data_out = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (start_cmd) begin
                m_rw = rw_bit; m_ptr = data_in;
                if (hang_once) begin
                    hang_once = 0; i2c_done = 0; i2c_busy = 1;
                    for (int k = 0; k < 1000 && !i2c_rst_req; k++) begin @(posedge clk); #1; end
                    i2c_busy = 0;
                end else if (nak_once && !m_rw) begin
                    nak_once = 0; i2c_done = 0; i2c_busy = 1;
                    repeat (2) begin @(posedge clk); #1; end
                    i2c_busy = 0; i2c_done = 1; i2c_error = 1;
                    @(posedge clk); #1;
                    i2c_error = 0; i2c_done = 0;
                end else begin
                    if (stale_mode) begin
                        repeat (3) begin @(posedge clk); #1; end
                    end
                    i2c_done = 0; i2c_busy = 1;
                    repeat (slow_mode ? 20 : 4) begin @(posedge clk); #1; end
                    if (m_rw) i2c_data_out = regmem[last_ptr];
                    else last_ptr = m_ptr;
                    i2c_busy = 0; i2c_done = 1;
                end
            end
        end
    end

    // NAK-only master for the saturation instance, with its own checks
    initial begin
        s_busy = 0; s_error = 0;
        forever begin
            @(posedge clk); #1;
            s_error = 0;
            if (s_start) s_busy = 1;
            else if (s_busy) begin s_busy = 0; s_error = 1; end
        end
    end

    initial forever begin
        @(negedge clk);
        if (s_serr) begin
            s_n++;
            if (s_n == 1 || s_n == 255 || s_n == 256 || s_n == 300)
                check($sformatf("sat_errcnt_%0d", s_n), {24'd0, s_errcnt},
                      (s_n > 255) ? 32'd255 : 32'(s_n));
            if (s_n == 300) s_enable = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int v0, e0, q0;
        for (int i = 0; i < 256; i++) regmem[i] = 8'h00;
        regmem[8'h3B] = 8'hA5; regmem[8'h3C] = 8'h5A;
        rst = 1; enable = 0; s_rst = 1; s_enable = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_addr", {25'd0, slave_addr}, 32'h68);
        check("reset_last", {31'd0, last_byte}, 32'd1);
        @(posedge clk); #1;
        rst = 0; s_rst = 0; enable = 1;

        // normal read
        b = st_rw.size();
        wait_valid(2500, "norm");
        check("norm_nstart", 32'(st_rw.size() - b), 32'd4);
        if (st_rw.size() >= b + 4) begin
            check("norm_rw0", {31'd0, st_rw[b]},   32'd0);
            check("norm_rw1", {31'd0, st_rw[b+1]}, 32'd1);
            check("norm_rw2", {31'd0, st_rw[b+2]}, 32'd0);
            check("norm_rw3", {31'd0, st_rw[b+3]}, 32'd1);
            check("norm_ptr0", {24'd0, st_data[b]},   32'h3B);
            check("norm_ptr1", {24'd0, st_data[b+2]}, 32'h3C);
        end
        check("norm_data", {16'd0, sample_data}, 32'hA55A);
        check("norm_errcnt", {24'd0, err_count}, 32'd0);
        check("norm_nvalid", 32'(valid_cnt), 32'd1);

        // NAK on the first write
        e0 = errp_cnt; q0 = rstreq_cnt; v0 = valid_cnt;
        nak_once = 1;
        wait_err(2500, "nak");
        repeat (5) @(posedge clk);
        check("nak_nerr", 32'(errp_cnt - e0), 32'd1);
        check("nak_nrstreq", 32'(rstreq_cnt - q0), 32'd1);
        check("nak_errcnt", {24'd0, err_count}, 32'd1);
        check("nak_data_kept", {16'd0, sample_data}, 32'hA55A);
        check("nak_novalid", 32'(valid_cnt - v0), 32'd0);
        regmem[8'h3B] = 8'h12; regmem[8'h3C] = 8'h34;
        wait_valid(2500, "after_nak");
        check("after_nak_data", {16'd0, sample_data}, 32'h1234);
        check("after_nak_errcnt", {24'd0, err_count}, 32'd1);

        // hung transaction, from a fresh reset
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        q0 = rstreq_cnt;
        hang_once = 1;
        b = st_cyc.size();
        wait_err(2500, "hang");
        check("hang_errcnt", {24'd0, err_count}, 32'd1);
        if (st_cyc.size() > b)
            check("hang_latency", 32'(last_err_cyc - st_cyc[b]), 32'd201);
        repeat (3) @(posedge clk);
        check("hang_nrstreq", 32'(rstreq_cnt - q0), 32'd1);

        // stale done from the master
        regmem[8'h3B] = 8'hA5; regmem[8'h3C] = 8'h5A;
        stale_mode = 1;
        b = st_rw.size();
        wait_valid(2500, "stale");
        stale_mode = 0;
        check("stale_data", {16'd0, sample_data}, 32'hA55A);
        check("stale_nstart", 32'(st_rw.size() - b), 32'd4);
        if (st_rw.size() >= b + 2) begin
            check("stale_rw1", {31'd0, st_rw[b+1]}, 32'd1);
            check("stale_gap", {31'd0, (st_cyc[b+1] - st_cyc[b]) >= 8}, 32'd1);
        end

        // reset in the middle of RD_WAIT
        slow_mode = 1;
        b = st_rw.size();
        wait_starts(b + 2, 2500, "rstmid");
        repeat (5) @(posedge clk);
        #1 rst = 1;
        v0 = valid_cnt; e0 = errp_cnt; q0 = rstreq_cnt;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check_reset_outputs("rstmid");
        repeat (50) @(posedge clk);
        check("rstmid_nopulse", 32'((valid_cnt - v0) + (errp_cnt - e0) + (rstreq_cnt - q0)), 32'd0);
        slow_mode = 0;

        // enable dropped mid-sample
        b = st_rw.size();
        wait_starts(b + 1, 2500, "endrop");
        #1 enable = 0;
        wait_valid(300, "endrop");
        check("endrop_data", {16'd0, sample_data}, 32'hA55A);
        check("endrop_nstart", 32'(st_rw.size() - b), 32'd4);
        b = st_rw.size();
        repeat (3000) @(posedge clk);
        check("endrop_quiet", 32'(st_rw.size() - b), 32'd0);

        // saturation instance
        for (int k = 0; k < 6000 && s_n < 300; k++) @(posedge clk);
        repeat (40) @(posedge clk);
        check("sat_npulses", 32'(s_n), 32'd300);
        check("sat_final", {24'd0, s_errcnt}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_sensor_poller.md
# i2c_sensor_poller

Periodic register-read sequencer sitting directly upstream of the I2C master (`i2c_master`). On every poll tick it reads NUM_BYTES consecutive registers from one slave. Each byte uses two master transactions: a pointer write, then a single-byte read. Bytes are assembled into a sample word and handed downstream with a one-cycle valid pulse. NAK, master error and hung transactions are turned into a counted error pulse plus a master reset request.

## Interface
- POLL_CYCLES, 5_000_000: clk cycles between poll ticks (100 ms at 50 MHz); ≥ 2.
- SLAVE_ADDR, 7'h68: 7-bit target address.
- REG_BASE, 8'h3B: first register pointer; byte i reads REG_BASE+i (mod 256).
- NUM_BYTES, 6: bytes per sample, 1..16.
- TIMEOUT_CYCLES, 100_000: max clk cycles per transaction, measured from start_cmd to completion.

Ports:
- clk  in  1  system clock.
- rst  in  1  **synchronous, active-high** reset.
- enable  in  1  polling enable.
- i2c_busy  in  1  master busy.
- i2c_done  in  1  master done.
- i2c_error  in  1  master NAK error.
- i2c_data_out  in  8  master read byte.
- start_cmd  out  1  one-cycle transaction request.
- slave_addr  out  7  constant SLAVE_ADDR.
- rw_bit  out  1  0 = write, 1 = read.
- data_in  out  8  register pointer for write transactions.
- last_byte  out  1  constant 1 (every read is single-byte, then NACK + STOP).
- i2c_rst_req  out  1  one-cycle pulse; top level ORs it into the master's rst.
- sample_data  out  8*NUM_BYTES  byte 0 in the MSBs.
- sample_valid  out  1  one-cycle pulse: sample_data updated.
- sample_error  out  1  one-cycle pulse: sample aborted.
- err_count  out  8  saturating count of aborted samples.

## Operation
States:
- IDLE: wait for a tick while enable=1; then idx←0 → WR_START.
- WR_START: start_cmd=1 for one cycle with rw_bit=0 and data_in=REG_BASE+idx → WR_ACK.
- WR_ACK: wait for i2c_busy=1 → WR_WAIT.
- WR_WAIT: on i2c_busy=0 && i2c_done=1 → RD_START.
- RD_START: start_cmd=1 for one cycle with rw_bit=1 → RD_ACK.
- RD_ACK: wait for i2c_busy=1 → RD_WAIT.
- RD_WAIT: on i2c_busy=0 && i2c_done=1, capture i2c_data_out into byte idx of a shadow register. If idx=NUM_BYTES-1 → DONE; else idx+1 → WR_START.
- DONE: copy shadow into sample_data, pulse sample_valid → IDLE.
- FAIL: pulse i2c_rst_req and sample_error, err_count+1 (saturate at 255) → IDLE. sample_data keeps its previous value.

Transitions into FAIL:
- from WR_ACK, WR_WAIT, RD_ACK or RD_WAIT when i2c_error=1;
- from the same states when the transaction timer reaches TIMEOUT_CYCLES.

Rules:
- rw_bit and data_in are held stable from start_cmd until the transaction completes or fails. The master samples them late in the transaction.
- Poll timer is free-running while enable=1 and cleared while enable=0. Tick = one cycle when the timer wraps from POLL_CYCLES-1 to 0.
- A tick that arrives outside IDLE is dropped, not queued.
- enable deasserted mid-sample: the current sample runs to DONE or FAIL, then the block stays in IDLE.
- Completion is accepted only after busy has been seen high (the ACK states). This masks the master's stale done from the previous transaction.
- Simultaneous i2c_error and completion: error wins → FAIL.

## Timing
- Reset values: state IDLE, start_cmd 0, rw_bit 0, data_in REG_BASE, i2c_rst_req 0, sample_data 0, sample_valid 0, sample_error 0, err_count 0, timers 0.
- rst asserted mid-sample: next edge forces all reset values. No pulse is emitted.
- All outputs are registered.
- start_cmd is high exactly one cycle, the cycle after entering *_START.
- sample_valid is high one cycle, the cycle after the final RD_WAIT completion. sample_data changes on the same edge.
- Transaction timer: cleared in *_START, incremented every cycle in the ACK/WAIT states. FAIL when count = TIMEOUT_CYCLES. FAIL lasts one cycle.
- Sample-to-sample minimum spacing: POLL_CYCLES.

## Test plan
Bench settings: POLL_CYCLES=1000, NUM_BYTES=2, TIMEOUT_CYCLES=200, REG_BASE=8'h3B, with a behavioural master model.

- Normal read: enable=1, model returns 8'hA5 then 8'h5A.
  - Expect start_cmd sequence rw 0/1/0/1 with data_in 3B then 3C.
  - Expect one sample_valid with sample_data=16'hA55A, err_count=0.
- NAK: model raises i2c_error during the first write.
  - Expect FAIL: i2c_rst_req and sample_error pulse once, err_count=1, sample_data unchanged.
  - Next tick yields a normal sample.
- Hang: model asserts busy and never completes.
  - Expect sample_error exactly 201 cycles after start_cmd, err_count=1.
- Stale done: model leaves done=1 and raises busy 3 cycles after start_cmd.
  - Expect no premature RD_START; data still 16'hA55A.
- Reset and enable: rst mid-RD_WAIT → all outputs at reset values next cycle, no pulses. enable dropped mid-sample → that sample completes, then no further start_cmd for ≥ 3000 cycles.
- Saturation: force 300 consecutive NAK samples → err_count holds at 255.
